hvgen_param: RTL and testbench
==============================

Name: hvgen_param

Overview:
- Parametrised successor to the fixed 288x224 video timing generator used by the arcade cores.
- Runs on the core master clock and advances only on a pixel clock enable, so no derived clock is needed.
- Produces HPOS/VPOS for the game core, registered blanking and sync, and a blanked RGB output.
- New features: frame-latched sync position adjust, dim mode, and line/frame start pulses for the scaler and high-score logic.

Parameters:
CW, 9, counter width of HPOS/VPOS
RGB_W, 12, RGB bus width; three equal channels of RGB_W/3 bits, {b,g,r} order
H_ACT, 288, first horizontal count that is blanked; active pixels are 0..H_ACT-1
H_SS, 311, nominal HSYNC start count
H_SE, 342, HSYNC end count and horizontal jump-from count
H_JMP, 471, count loaded after H_SE
H_END, 511, last count of a line; the next count is 0
V_ACT, 224, first blanked line
V_SS, 226, nominal VSYNC start line
V_SE, 233, VSYNC end line and vertical jump-from line
V_JMP, 483, line loaded after V_SE
V_END, 511, last line of a frame

Ports:
MCLK  in  1  master clock
RESET_N  in  1  asynchronous active-low reset
PCE  in  1  pixel clock enable, one MCLK wide
HADJ  in  4  signed horizontal sync adjust, -8..+7
VADJ  in  4  signed vertical sync adjust, -8..+7
DIM  in  1  halve output intensity
iRGB  in  RGB_W  pixel from the core, for the current HPOS/VPOS
HPOS  out  CW  horizontal counter
VPOS  out  CW  vertical counter
oRGB  out  RGB_W  blanked (optionally dimmed) pixel
HBLK  out  1  horizontal blank
VBLK  out  1  vertical blank
HSYN_N  out  1  active-low HSYNC
VSYN_N  out  1  active-low VSYNC
LINE_START  out  1  one-MCLK pulse at line wrap
FRAME_START  out  1  one-MCLK pulse at frame wrap

Behaviour:
- Reset is asynchronous and active-low: MCLK single clock, RESET_N asynchronous active-low.
- Reset values: hcnt=0, vcnt=0, HBLK=1, VBLK=1, HSYN_N=1, VSYN_N=1, oRGB=0, LINE_START=0, FRAME_START=0, latched adjusts=0.
- After RESET_N releases, counting starts on the first PCE.
- All state changes only on an MCLK edge with PCE=1, except the two pulses.
- HPOS=hcnt and VPOS=vcnt, driven directly from the counter registers.
- Horizontal sequence: hcnt==H_SE loads H_JMP; hcnt==H_END loads 0 and steps vcnt; otherwise hcnt+1.
- Vertical sequence: vcnt==V_SE loads V_JMP; vcnt==V_END loads 0; otherwise vcnt+1.
- Sync windows:
  - hs_start = clamp(H_SS + hadj_l, H_ACT, H_SE-1), computed in CW+2 signed.
  - vs_start = clamp(V_SS + vadj_l, V_ACT, V_SE-1), same width rule.
- Registered outputs, updated on PCE from the current counter values, giving 1-PCE latency aligned with iRGB:
  - HBLK = hcnt >= H_ACT
  - VBLK = vcnt >= V_ACT
  - HSYN_N = !(hs_start <= hcnt < H_SE)
  - VSYN_N = !(vs_start <= vcnt < V_SE)
  - oRGB = (HBLK|VBLK, same decode) ? 0 : (DIM ? each channel >>1 : iRGB)
- HADJ/VADJ are sampled into hadj_l/vadj_l only on the PCE where hcnt==H_END and vcnt==V_END. Mid-frame changes have no effect until the next frame.
- LINE_START is high for exactly one MCLK, the cycle after the PCE on which hcnt wraps to 0.
- FRAME_START is high under the same rule when vcnt also wraps to 0, coincident with LINE_START.
- Back-to-back PCE (every MCLK) is legal. The pulses are then still one MCLK wide and never merge, since a line is at least two PCE.
- With defaults: 384 PCE per line (96 blanked), 263 lines per frame (39 blanked), 100992 PCE per frame.
- If RESET_N asserts mid-frame, all outputs immediately take their reset values; no partial pulse remains.

Test Plan:
1. Reset, PCE every MCLK -> HPOS runs 0..342, then 471..511, then 0; LINE_START period is 384 MCLK; HBLK high for 96 PCE per line; HSYN_N low for hcnt 311..341 (31 PCE).
2. Full frame -> VPOS runs 0..233, then 483..511; FRAME_START exactly once per 100992 PCE; VBLK high for 39 lines; VSYN_N low on lines 226..232.
3. PCE 1-in-4 -> counters and outputs change only on PCE cycles; LINE_START period is 1536 MCLK and remains one MCLK wide.
4. HADJ=-8 applied mid-frame -> no change in the current frame. Next frame: HSYN_N low for 303..341 (39 PCE). HADJ=+7 -> low for 318..341. VADJ=+7 -> clamped to line 232, so one line of VSYNC.
5. iRGB=12'hFFF in the active area with DIM=1 -> oRGB=12'h777 one PCE later. During HBLK or VBLK -> oRGB=0 regardless of iRGB and DIM.
6. RESET_N pulled low at hcnt=150, vcnt=100 -> outputs take reset values within the same MCLK cycle, before any edge. After release, HPOS resumes counting from 0.

Source files
------------

// File: rtl/hvgen_param.sv
// hvgen_param: parametrised video timing generator.
// Counts pixels on a clock enable and produces HPOS/VPOS, registered blanking
// and sync, a blanked/dimmed RGB output, and line/frame start pulses.
module hvgen_param #(
    parameter int unsigned CW    = 9,
    parameter int unsigned RGB_W = 12,
    parameter int unsigned H_ACT = 288,
    parameter int unsigned H_SS  = 311,
    parameter int unsigned H_SE  = 342,
    parameter int unsigned H_JMP = 471,
    parameter int unsigned H_END = 511,
    parameter int unsigned V_ACT = 224,
    parameter int unsigned V_SS  = 226,
    parameter int unsigned V_SE  = 233,
    parameter int unsigned V_JMP = 483,
    parameter int unsigned V_END = 511
) (
    input  logic             MCLK,
    input  logic             RESET_N,
    input  logic             PCE,
    input  logic [3:0]       HADJ,
    input  logic [3:0]       VADJ,
    input  logic             DIM,
    input  logic [RGB_W-1:0] iRGB,
    output logic [CW-1:0]    HPOS,
    output logic [CW-1:0]    VPOS,
    output logic [RGB_W-1:0] oRGB,
    output logic             HBLK,
    output logic             VBLK,
    output logic             HSYN_N,
    output logic             VSYN_N,
    output logic             LINE_START,
    output logic             FRAME_START
);

    localparam int unsigned CH_W = RGB_W / 3;
    localparam int unsigned SW   = CW + 2;

    logic [CW-1:0]    r_hcnt;
    logic [CW-1:0]    r_vcnt;
    logic [3:0]       r_hadj;
    logic [3:0]       r_vadj;
    logic             r_hblk;
    logic             r_vblk;
    logic             r_hsyn_n;
    logic             r_vsyn_n;
    logic [RGB_W-1:0] r_rgb;
    logic             r_line_start;
    logic             r_frame_start;

    logic [CW-1:0]    w_hcnt_nxt;
    logic [CW-1:0]    w_vcnt_nxt;
    logic             w_h_end;
    logic             w_v_end;
    logic [SW-1:0]    w_hs_start;
    logic [SW-1:0]    w_vs_start;
    logic             w_hblk;
    logic             w_vblk;
    logic             w_hsync;
    logic             w_vsync;
    logic [RGB_W-1:0] w_rgb_dim;

    // Nominal sync start plus signed adjust, clamped into the blanking window
    function automatic logic [SW-1:0] sync_start(input logic [3:0] adj,
                                                 input int unsigned nom,
                                                 input int unsigned lo,
                                                 input int unsigned hi);
        logic signed [SW-1:0] sum;
        sum = $signed(SW'(nom)) + $signed({{(SW-4){adj[3]}}, adj});
        if (sum < $signed(SW'(lo)))
            return SW'(lo);
        else if (sum > $signed(SW'(hi)))
            return SW'(hi);
        else
            return sum;
    endfunction

    assign w_h_end    = (r_hcnt == CW'(H_END));
    assign w_v_end    = (r_vcnt == CW'(V_END));
    assign w_hs_start = sync_start(r_hadj, H_SS, H_ACT, H_SE - 1);
    assign w_vs_start = sync_start(r_vadj, V_SS, V_ACT, V_SE - 1);
    assign w_hblk     = (r_hcnt >= CW'(H_ACT));
    assign w_vblk     = (r_vcnt >= CW'(V_ACT));
    assign w_hsync    = ({2'b00, r_hcnt} >= w_hs_start) && (r_hcnt < CW'(H_SE));
    assign w_vsync    = ({2'b00, r_vcnt} >= w_vs_start) && (r_vcnt < CW'(V_SE));

    // Next counter values: jump over the sync-to-end gap, wrap at end
    always_comb begin
        w_hcnt_nxt = r_hcnt + CW'(1);
        w_vcnt_nxt = r_vcnt;
        if (r_hcnt == CW'(H_SE)) begin
            w_hcnt_nxt = CW'(H_JMP);
        end else if (w_h_end) begin
            w_hcnt_nxt = '0;
            if (r_vcnt == CW'(V_SE))
                w_vcnt_nxt = CW'(V_JMP);
            else if (w_v_end)
                w_vcnt_nxt = '0;
            else
                w_vcnt_nxt = r_vcnt + CW'(1);
        end
    end

    // Halve each colour channel for dim mode
    always_comb begin
        w_rgb_dim = '0;
        for (int c = 0; c < 3; c++) begin
            w_rgb_dim[c*CH_W +: CH_W] = {1'b0, iRGB[c*CH_W+1 +: CH_W-1]};
        end
    end

    // Counters, frame-latched adjusts, registered video outputs and pulses
    always_ff @(posedge MCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_hcnt        <= '0;
            r_vcnt        <= '0;
            r_hadj        <= '0;
            r_vadj        <= '0;
            r_hblk        <= 1'b1;
            r_vblk        <= 1'b1;
            r_hsyn_n      <= 1'b1;
            r_vsyn_n      <= 1'b1;
            r_rgb         <= '0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_line_start  <= PCE && w_h_end;
            r_frame_start <= PCE && w_h_end && w_v_end;
            if (PCE) begin
                r_hcnt   <= w_hcnt_nxt;
                r_vcnt   <= w_vcnt_nxt;
                r_hblk   <= w_hblk;
                r_vblk   <= w_vblk;
                r_hsyn_n <= !w_hsync;
                r_vsyn_n <= !w_vsync;
                r_rgb    <= (w_hblk || w_vblk) ? '0 : (DIM ? w_rgb_dim : iRGB);
                if (w_h_end && w_v_end) begin
                    r_hadj <= HADJ;
                    r_vadj <= VADJ;
                end
            end
        end
    end

    assign HPOS        = r_hcnt;
    assign VPOS        = r_vcnt;
    assign oRGB        = r_rgb;
    assign HBLK        = r_hblk;
    assign VBLK        = r_vblk;
    assign HSYN_N      = r_hsyn_n;
    assign VSYN_N      = r_vsyn_n;
    assign LINE_START  = r_line_start;
    assign FRAME_START = r_frame_start;

endmodule

// File: tb/tb_hvgen_param.sv
// Self-checking bench for hvgen_param. Horizontal timing is the default;
// vertical timing is shortened so that several whole frames fit in the run.
module tb_hvgen_param;

    localparam int H_ACT = 288, H_SS = 311, H_SE = 342, H_JMP = 471, H_END = 511;
    localparam int V_ACT = 4, V_SS = 6, V_SE = 9, V_JMP = 13, V_END = 15;
    localparam int PPL   = (H_SE + 1) + (H_END - H_JMP + 1);
    localparam int LINES = (V_SE + 1) + (V_END - V_JMP + 1);
    localparam int FRAME = PPL * LINES;

    logic        MCLK = 1'b0;
    logic        RESET_N, PCE, DIM;
    logic [3:0]  HADJ, VADJ;
    logic [11:0] iRGB;
    logic [8:0]  HPOS, VPOS;
    logic [11:0] oRGB;
    logic        HBLK, VBLK, HSYN_N, VSYN_N, LINE_START, FRAME_START;

    hvgen_param #(
        .CW(9), .RGB_W(12),
        .H_ACT(H_ACT), .H_SS(H_SS), .H_SE(H_SE), .H_JMP(H_JMP), .H_END(H_END),
        .V_ACT(V_ACT), .V_SS(V_SS), .V_SE(V_SE), .V_JMP(V_JMP), .V_END(V_END)
    ) dut (
        .MCLK(MCLK), .RESET_N(RESET_N), .PCE(PCE), .HADJ(HADJ), .VADJ(VADJ),
        .DIM(DIM), .iRGB(iRGB), .HPOS(HPOS), .VPOS(VPOS), .oRGB(oRGB),
        .HBLK(HBLK), .VBLK(VBLK), .HSYN_N(HSYN_N), .VSYN_N(VSYN_N),
        .LINE_START(LINE_START), .FRAME_START(FRAME_START)
    );

    always #5 MCLK = ~MCLK;

    int checks = 0;
    int errors = 0;

    // reference model state
    int mh, mv, mhadj, mvadj;
    logic e_hblk, e_vblk, e_hsn, e_vsn, e_ls, e_fs;
    logic [11:0] e_rgb;

    // stimulus / statistics state
    bit rand_px = 1'b1;
    int phase, cyc;
    int exp_period, last_ls, n_ls, n_fs, n_hblk, n_vblk, n_hs, n_vs, hs_min, hs_max;
    bit have_ls, ls_prev;

    function automatic int clampi(input int x, input int lo, input int hi);
        return (x < lo) ? lo : ((x > hi) ? hi : x);
    endfunction

    function automatic int sext4(input logic [3:0] a);
        return (int'(a) >= 8) ? int'(a) - 16 : int'(a);
    endfunction

    task automatic model_reset();
        mh = 0; mv = 0; mhadj = 0; mvadj = 0;
        e_hblk = 1; e_vblk = 1; e_hsn = 1; e_vsn = 1; e_ls = 0; e_fs = 0; e_rgb = '0;
    endtask

    // One MCLK edge of the reference: outputs describe the position before the edge
    task automatic model_step();
        int hs, vs;
        e_ls = 0; e_fs = 0;
        if (PCE) begin
            hs = clampi(H_SS + mhadj, H_ACT, H_SE - 1);
            vs = clampi(V_SS + mvadj, V_ACT, V_SE - 1);
            e_hblk = (mh >= H_ACT);
            e_vblk = (mv >= V_ACT);
            e_hsn  = !(mh >= hs && mh < H_SE);
            e_vsn  = !(mv >= vs && mv < V_SE);
            if (e_hblk || e_vblk) e_rgb = '0;
            else if (DIM)         e_rgb = {iRGB[11:8] >> 1, iRGB[7:4] >> 1, iRGB[3:0] >> 1};
            else                  e_rgb = iRGB;
            if (mh == H_END) begin
                e_ls = 1;
                if (mv == V_END) begin
                    e_fs = 1;
                    mhadj = sext4(HADJ);
                    mvadj = sext4(VADJ);
                end
            end
            if (mh == H_SE) mh = H_JMP;
            else if (mh == H_END) begin
                mh = 0;
                if (mv == V_SE) mv = V_JMP;
                else if (mv == V_END) mv = 0;
                else mv = mv + 1;
            end else mh = mh + 1;
        end
    endtask

    task automatic check_all(input string tag);
        logic [35:0] obs, exp;
        obs = {HPOS, VPOS, HBLK, VBLK, HSYN_N, VSYN_N, LINE_START, FRAME_START, oRGB};
        exp = {9'(mh), 9'(mv), e_hblk, e_vblk, e_hsn, e_vsn, e_ls, e_fs, e_rgb};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s t=%0t observed=%h expected=%h", tag, $time, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic stats_clear(input int period);
        exp_period = period; have_ls = 0; ls_prev = 0;
        n_ls = 0; n_fs = 0; n_hblk = 0; n_vblk = 0; n_hs = 0; n_vs = 0;
        hs_min = 9999; hs_max = -1;
    endtask

    // Drive one cycle (div 0 = random PCE), step the model, sample at negedge
    task automatic tick(input int div);
        int h_src;
        bit pce_now;
        PCE = (div == 0) ? 1'($urandom_range(0, 1)) : ((phase % div) == 0);
        phase++;
        if (rand_px) begin
            iRGB = 12'($urandom);
            DIM  = 1'($urandom_range(0, 1));
        end
        pce_now = PCE;
        h_src   = int'(HPOS);
        @(posedge MCLK);
        model_step();
        @(negedge MCLK);
        cyc++;
        check_all("cyc");
        if (pce_now) begin
            if (HBLK)    n_hblk++;
            if (VBLK)    n_vblk++;
            if (!VSYN_N) n_vs++;
            if (!HSYN_N) begin
                n_hs++;
                if (h_src < hs_min) hs_min = h_src;
                if (h_src > hs_max) hs_max = h_src;
            end
        end
        if (LINE_START) begin
            n_ls++;
            check_int("ls_width", int'(ls_prev), 0);
            if (exp_period != 0 && have_ls) check_int("ls_period", cyc - last_ls, exp_period);
            last_ls = cyc;
            have_ls = 1;
        end
        if (FRAME_START) n_fs++;
        ls_prev = LINE_START;
    endtask

    task automatic run(input int n, input int div);
        phase = 0;
        for (int i = 0; i < n; i++) tick(div);
    endtask

    initial begin
        bit found;
        RESET_N = 0; PCE = 0; HADJ = 0; VADJ = 0; DIM = 0; iRGB = '0;
        cyc = 0; phase = 0;
        model_reset();
        stats_clear(0);
        repeat (3) @(negedge MCLK);
        check_all("reset");
        RESET_N = 1;

        // frame 1: nominal timing, PCE every MCLK
        stats_clear(PPL);
        run(FRAME, 1);
        check_int("f1_line_starts", n_ls, LINES);
        check_int("f1_frame_starts", n_fs, 1);
        check_int("f1_hblk_pce", n_hblk, LINES * (PPL - H_ACT));
        check_int("f1_vblk_pce", n_vblk, (LINES - V_ACT) * PPL);
        check_int("f1_hsync_pce", n_hs, LINES * (H_SE - H_SS));
        check_int("f1_hsync_first", hs_min, H_SS);
        check_int("f1_hsync_last", hs_max, H_SE - 1);
        check_int("f1_vsync_pce", n_vs, (V_SE - V_SS) * PPL);

        // frame 2: HADJ=-8 mid-frame must not affect this frame
        stats_clear(PPL);
        run(2000, 1);
        HADJ = 4'b1000;
        run(FRAME - 2000, 1);
        check_int("f2_hsync_first", hs_min, H_SS);
        check_int("f2_hsync_pce", n_hs, LINES * (H_SE - H_SS));
        check_int("f2_frame_starts", n_fs, 1);

        // frame 3: -8 in force; queue +7/+7 for the next frame
        stats_clear(PPL);
        run(100, 1);
        HADJ = 4'd7; VADJ = 4'd7;
        run(FRAME - 100, 1);
        check_int("f3_hsync_first", hs_min, H_SS - 8);
        check_int("f3_hsync_last", hs_max, H_SE - 1);
        check_int("f3_hsync_pce", n_hs, LINES * (H_SE - H_SS + 8));
        check_int("f3_vsync_pce", n_vs, (V_SE - V_SS) * PPL);

        // frame 4: +7 horizontal, vertical clamped to a single line
        stats_clear(PPL);
        run(100, 1);
        HADJ = 4'd0; VADJ = 4'b1000;
        run(FRAME - 100, 1);
        check_int("f4_hsync_first", hs_min, H_SS + 7);
        check_int("f4_hsync_pce", n_hs, LINES * (H_SE - H_SS - 7));
        check_int("f4_vsync_pce", n_vs, PPL);

        // frame 5: VADJ=-8 clamps vsync start to the first blanked line
        stats_clear(PPL);
        run(FRAME, 1);
        check_int("f5_vsync_pce", n_vs, (V_SE - V_ACT) * PPL);
        check_int("f5_hsync_first", hs_min, H_SS);

        // directed pixel path
        rand_px = 0;
        iRGB = 12'hFFF; DIM = 1;
        tick(1);
        check_int("dim_fff", int'(oRGB), 12'h777);
        iRGB = 12'hABC; DIM = 0;
        tick(1);
        check_int("pass_abc", int'(oRGB), 12'hABC);
        iRGB = 12'hFFF; DIM = 1;
        run(300, 1);
        check_int("hblank_dim", int'(oRGB), 0);
        DIM = 0;
        tick(1);
        check_int("hblank_nodim", int'(oRGB), 0);
        found = 0;
        for (int i = 0; i < FRAME && !found; i++) begin
            tick(1);
            found = (HPOS == 9'd10 && VPOS == 9'd5);
        end
        check_int("reach_vblank", int'(found), 1);
        tick(1);
        check_int("vblank_rgb", int'(oRGB), 0);
        rand_px = 1;

        // PCE 1-in-4
        stats_clear(4 * PPL);
        run(4 * PPL * 3 + 8, 4);
        check_int("div4_line_starts_ge2", int'(n_ls >= 2), 1);

        // random PCE
        stats_clear(0);
        run(2000, 0);

        // asynchronous reset in mid-frame
        found = 0;
        for (int i = 0; i < 2 * FRAME && !found; i++) begin
            tick(1);
            found = (HPOS == 9'd150 && VPOS == 9'd2);
        end
        check_int("reach_mid", int'(found), 1);
        #1 RESET_N = 0;
        #1;
        model_reset();
        check_all("reset_mid");
        @(negedge MCLK);
        check_all("reset_hold");
        RESET_N = 1;
        stats_clear(PPL);
        run(800, 1);
        check_int("after_reset_ls", n_ls, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
